// File: rtl/button_enable_gen.sv
// button_enable_gen: raw push-button to clean single-cycle enable pulses with optional auto-repeat
// Ports:
//   clk       in   clock; all state updates on the rising edge
//   rst       in   asynchronous active-low reset
//   btn_raw   in   raw, bouncing, asynchronous button level (active-high)
//   en        out  registered one-cycle enable pulse per accepted press / repeat
//   btn_level out  registered debounced button level
module button_enable_gen #(
    parameter int DB_CYCLES     = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic en,
    output logic btn_level
);
    typedef enum logic [2:0] {IDLE, PRESS_DB, HELD, REPEAT, REL_DB} state_t;

    // HOLD_LAST is meaningless when HOLD_CYCLES is 0; every use is guarded
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state;
    logic             s1;
    logic             btn_s;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1        <= 1'b0;
            btn_s     <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            en        <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            s1    <= btn_raw;
            btn_s <= s1;
            en    <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (btn_s) state <= PRESS_DB;
                end
                PRESS_DB: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= HELD;
                        cnt       <= '0;
                        btn_level <= 1'b1;
                        en        <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    // release takes priority over a simultaneous terminal count
                    if (!btn_s) begin
                        state <= REL_DB;
                        cnt   <= '0;
                    end else if (HOLD_CYCLES != 0 && cnt == HOLD_LAST) begin
                        state <= REPEAT;
                        cnt   <= '0;
                        en    <= 1'b1;
                    end else if (HOLD_CYCLES != 0) begin
                        // with auto-repeat disabled the timer stays parked at 0
                        cnt <= cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!btn_s) begin
                        state <= REL_DB;
                        cnt   <= '0;
                    end else if (cnt == REP_LAST) begin
                        cnt <= '0;
                        en  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REL_DB: begin
                    // a bounce back to 1 returns to HELD with a fresh hold timer
                    if (btn_s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_button_enable_gen.sv
// tb_button_enable_gen: scoreboard bench for button_enable_gen pulse timing and debounced level
module tb_button_enable_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_raw = 1'b0;
    logic btn_raw2 = 1'b0;
    logic en, btn_level, en2, btn_level2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int act_q[$];
    int act2_q[$];

    button_enable_gen dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .en(en), .btn_level(btn_level)
    );

    button_enable_gen #(.HOLD_CYCLES(0)) dut2 (
        .clk(clk), .rst(rst), .btn_raw(btn_raw2), .en(en2), .btn_level(btn_level2)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // record the edge index of every cycle in which a pulse is visible
    always @(negedge clk) begin
        if (en) act_q.push_back(cyc);
        if (en2) act2_q.push_back(cyc);
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        check({tag, "_count"}, act_q.size(), exp_q.size());
        while (exp_q.size() > 0 && act_q.size() > 0)
            check({tag, "_edge"}, act_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        act_q.delete();
    endtask

    initial begin
        int k, e, m, r;
        repeat (3) @(negedge clk);
        check("rst_en", int'(en), 0);
        check("rst_lvl", int'(btn_level), 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_en", int'(en), 0);
        check("idle_lvl", int'(btn_level), 0);
        check("idle_en2", int'(en2), 0);
        act_q.delete();
        act2_q.delete();

        // clean press held 10 cycles
        k = cyc;
        btn_raw = 1'b1;
        e = k + 7;
        exp_q.push_back(e);
        wait_cyc(e - 1);
        check("clean_lvl_pre", int'(btn_level), 0);
        wait_cyc(e);
        check("clean_lvl_rise", int'(btn_level), 1);
        wait_cyc(k + 10);
        btn_raw = 1'b0;
        m = k + 11;
        wait_cyc(m + 5);
        check("clean_lvl_hold", int'(btn_level), 1);
        wait_cyc(m + 6);
        check("clean_lvl_fall", int'(btn_level), 0);
        wait_cyc(m + 15);
        drain("clean");

        // press bounce 1,0,1,0 then rest at 0
        for (int i = 0; i < 4; i++) begin
            btn_raw = (i % 2 == 0);
            @(negedge clk);
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bounce_lvl", int'(btn_level), 0);
            @(negedge clk);
        end
        drain("bounce");

        // auto-repeat: held 60 cycles after the press pulse
        k = cyc;
        btn_raw = 1'b1;
        e = k + 7;
        exp_q.push_back(e);
        for (int t = 16; t <= 56; t += 8) exp_q.push_back(e + t);
        wait_cyc(e + 60);
        btn_raw = 1'b0;
        wait_cyc(e + 75);
        check("repeat_lvl_end", int'(btn_level), 0);
        drain("repeat");

        // release bounce: two low cycles right after the press pulse
        k = cyc;
        btn_raw = 1'b1;
        e = k + 7;
        exp_q.push_back(e);
        exp_q.push_back(e + 21);
        wait_cyc(e);
        btn_raw = 1'b0;
        wait_cyc(e + 2);
        btn_raw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("relb_lvl", int'(btn_level), 1);
            @(negedge clk);
        end
        wait_cyc(e + 24);
        btn_raw = 1'b0;
        wait_cyc(e + 40);
        drain("relbounce");

        // auto-repeat disabled: one pulse over a 100-cycle hold
        k = cyc;
        btn_raw2 = 1'b1;
        wait_cyc(k + 100);
        check("hold0_lvl", int'(btn_level2), 1);
        btn_raw2 = 1'b0;
        wait_cyc(k + 115);
        check("hold0_count", act2_q.size(), 1);
        if (act2_q.size() > 0) check("hold0_edge", act2_q[0], k + 7);
        check("hold0_lvl_end", int'(btn_level2), 0);
        drain("hold0_main");

        // reset asserted right after a repeat pulse, button kept high
        k = cyc;
        btn_raw = 1'b1;
        e = k + 7;
        exp_q.push_back(e);
        exp_q.push_back(e + 16);
        exp_q.push_back(e + 24);
        wait_cyc(e + 24);
        check("prerst_en", int'(en), 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_en", int'(en), 0);
        check("midrst_lvl", int'(btn_level), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        r = cyc + 1;
        exp_q.push_back(r + 6);
        @(negedge clk);
        wait_cyc(r + 5);
        check("postrst_lvl_pre", int'(btn_level), 0);
        wait_cyc(r + 6);
        check("postrst_lvl", int'(btn_level), 1);
        btn_raw = 1'b0;
        wait_cyc(r + 20);
        drain("reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_enable_gen.md
# button_enable_gen

Upstream enable source for the decade counter: turns a raw, asynchronous, bouncing push-button into clean single-cycle `en` pulses. Synchronises the input, debounces press and release, emits one pulse per accepted press, and optionally auto-repeats while the button is held. `en` drives the counter's `en` input directly; the block shares the counter's clock and reset.

## Interface
- `DB_CYCLES`, 4: consecutive stable synchronised samples needed to accept a press or release; min 1.
- `HOLD_CYCLES`, 16: cycles from the press pulse to the first auto-repeat pulse; 0 disables auto-repeat.
- `REPEAT_CYCLES`, 8: cycles between successive auto-repeat pulses; min 1.
- `CNT_W`, 8: internal counter width; must hold max(`DB_CYCLES`, `HOLD_CYCLES`, `REPEAT_CYCLES`) - 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `btn_raw`  in  1  raw button level, active-high; asynchronous to `clk`, may bounce.
- `en`  out  1  registered one-cycle enable pulse.
- `btn_level`  out  1  registered debounced button level.

## Operation
- Synchroniser: two flops, `btn_raw` -> `s1` -> `btn_s`. Only `btn_s` feeds the FSM.
- One shared counter `cnt`. It clears on every state change and increments on each cycle the FSM stays in a counting state.
- Reset (`rst`=0): `s1`, `btn_s`, `cnt`, `en` and `btn_level` all go to 0 and the state goes to IDLE, immediately and without waiting for a clock edge.
- IDLE:
  - `btn_s`=1 -> PRESS_DB.
- PRESS_DB:
  - `btn_s`=0 -> IDLE with no pulse (bounce is rejected).
  - `btn_s`=1 and `cnt`==`DB_CYCLES`-1 -> HELD; set `btn_level`=1; `en`=1 for that one cycle.
- HELD:
  - `btn_s`=0 -> REL_DB.
  - Otherwise, if `HOLD_CYCLES`!=0 and `cnt`==`HOLD_CYCLES`-1 -> REPEAT; `en`=1.
- REPEAT:
  - `btn_s`=0 -> REL_DB.
  - Otherwise, `cnt`==`REPEAT_CYCLES`-1 -> `en`=1 and `cnt` clears; stay in REPEAT.
- REL_DB:
  - `btn_s`=1 -> HELD; hold timer restarts and no pulse is issued (release bounce).
  - `btn_s`=0 and `cnt`==`DB_CYCLES`-1 -> IDLE; `btn_level`=0.
- `en` is never asserted in IDLE, PRESS_DB or REL_DB. Outside the transitions listed above it is 0.
- `btn_level` changes only on the PRESS_DB->HELD and REL_DB->IDLE transitions.

## Timing
- Let edge N be the first edge at which `s1` captures 1.
  - `btn_s`=1 after edge N+1.
  - PRESS_DB is entered at edge N+2.
  - `en` and `btn_level` rise at edge N+`DB_CYCLES`+2, if `btn_s` stays 1 throughout. With defaults this is N+6.
- Let edge E be the press-pulse edge.
  - First repeat pulse at edge E+`HOLD_CYCLES`.
  - Further repeat pulses every `REPEAT_CYCLES` edges after that.
- Release latency: `btn_level` falls `DB_CYCLES`+2 edges after `s1` first captures 0, provided `btn_s` stays 0.
- Pulse width: `en` is high for exactly one cycle. Two pulses are always separated by at least `min(HOLD_CYCLES, REPEAT_CYCLES)`-1 low cycles.
- Simultaneous events: in HELD or REPEAT, `btn_s`=0 on the same edge as a terminal count means release wins; no pulse is issued.
- Reset asserted mid-press or mid-repeat: `en` drops immediately. The next pulse requires a full new debounce from IDLE, even if the button is still held.
- Counter limit: `cnt` never exceeds the active terminal value minus 1. No wrap occurs within legal parameters.

## Test plan
- Clean press, defaults. `btn_raw` 0->1 held 10 cycles, then 0. Required: exactly one `en` pulse at edge N+6; `btn_level` 1 from N+6; `btn_level` back to 0 six edges after `s1` captures 0.
- Press bounce. `btn_raw` toggles 1,0,1,0 on consecutive cycles, then rests at 0. Required: `en` and `btn_level` stay 0 throughout.
- Auto-repeat with defaults. Hold 60 cycles after the press pulse at E. Required: pulses at E, E+16, E+24, E+32, E+40, E+48, E+56, each one cycle wide.
- Release bounce. After the press pulse, drop `btn_raw` for 2 cycles, then raise it again. Required: `btn_level` stays 1, no pulse, and the next repeat pulse comes 16 cycles after re-entering HELD.
- `HOLD_CYCLES`=0. Hold 100 cycles. Required: exactly one pulse.
- Reset mid-repeat. Assert `rst` low for 1 cycle while held in REPEAT, keeping `btn_raw`=1. Required: all outputs go to 0 immediately; the next pulse comes `DB_CYCLES`+2 edges after reset release.
